// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - ALU opcodes, special register addresses and decoded-instruction type
package decode_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_MOVE = 4'h2;
    localparam logic [3:0] ALU_ROR  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_PASS = 4'h7;
    localparam logic [3:0] ALU_ADDC = 4'h8;
    localparam logic [3:0] ALU_SUBC = 4'h9;
    localparam logic [3:0] ALU_NOT  = 4'hA;
    localparam logic [3:0] ALU_ROL  = 4'hB;
    localparam logic [3:0] ALU_NONE = 4'hF;

    localparam logic [4:0] REG_LINK   = 5'h11;
    localparam logic [4:0] REG_DATA   = 5'h18;
    localparam logic [4:0] REG_IO     = 5'h19;
    localparam logic [4:0] REG_STATUS = 5'h1E;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] src_raddr;
        logic [4:0] dest_waddr;
        logic       h_en;
        logic       l_en;
        logic       regf_wren;
        logic       data_wren;
        logic       data_ren;
        logic       io_wren;
        logic       io_ren;
        logic       status_ren;
        logic       pc_jmp;
        logic       pc_brx;
        logic       pc_brxt;
        logic       pc_call;
        logic       pc_ret;
    } dec_t;

endpackage

// File: rtl/decode_queue_fifo.sv
// rtl/decode_queue_fifo.sv - instruction word queue: storage, wrapping pointers and occupancy
module decode_queue_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // pointers wrap naturally because DEPTH is a power of two; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - fetch queue plus registered instruction decode; DECODE_QUEUE_BYPASS_EN enables empty-queue bypass
module decode_queue
    import decode_pkg::*;
#(
    parameter int            IW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [IW-1:0] NOP_WORD = 16'hC000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       hazard,
    input  logic                       jmp_rst,
    input  logic                       brx_rst,
    input  logic                       fetch_valid,
    input  logic [IW-1:0]              fetch_data,
    output logic                       fetch_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       dec_valid,
    output logic [3:0]                 alu_op,
    output logic [4:0]                 src_raddr,
    output logic [4:0]                 dest_waddr,
    output logic [IW-7:0]              I_field,
    output logic                       H_en,
    output logic                       L_en,
    output logic                       regf_wren,
    output logic                       data_wren,
    output logic                       data_ren,
    output logic                       IO_wren,
    output logic                       IO_ren,
    output logic                       status_ren,
    output logic                       pc_jmp,
    output logic                       pc_brx,
    output logic                       pc_brxt,
    output logic                       pc_call,
    output logic                       pc_ret
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          push, pop, q_empty, byp_load;
    logic [IW-1:0] head, word;
    logic          word_valid;
    logic [3:0]    cls;
    dec_t          dec_n, dec_q;
    logic [IW-7:0] ifield_q;
    logic          valid_q;

    assign fetch_ready = ~rst & ~flush & (q_count != FULL);
    assign push        = fetch_valid & fetch_ready;
    assign q_empty     = (q_count == '0);
    assign pop         = ~hazard & ~flush & ~q_empty;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp_load = q_empty & push & ~hazard;
`else
    assign byp_load = 1'b0;
`endif

    decode_queue_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push & ~byp_load),
        .pop   (pop),
        .wdata (fetch_data),
        .rdata (head),
        .count (q_count)
    );

    // choose the word entering decode: queue head, bypassed fetch word, or the idle NOP
    always_comb begin
        word       = NOP_WORD;
        word_valid = 1'b0;
        if (!q_empty) begin
            word       = head;
            word_valid = 1'b1;
        end else if (byp_load) begin
            word       = fetch_data;
            word_valid = 1'b1;
        end
    end

    // instruction decode keyed by the class nibble bits[15:12]
    always_comb begin
        cls              = word[15:12];
        dec_n            = '0;
        dec_n.src_raddr  = word[9:5];
        dec_n.dest_waddr = word[4:0];
        dec_n.h_en       = word[11];
        dec_n.l_en       = word[10];
        dec_n.pc_brxt    = word[12];
        case (cls)
            4'h0: dec_n.alu_op = ALU_ADD;
            4'h1: dec_n.alu_op = ALU_ADDC;
            4'h2: dec_n.alu_op = ALU_SUB;
            4'h3: dec_n.alu_op = ALU_SUBC;
            4'h4: dec_n.alu_op = ALU_MOVE;
            4'h5: dec_n.alu_op = ALU_NOT;
            4'h6: dec_n.alu_op = ALU_ROR;
            4'h7: dec_n.alu_op = ALU_ROL;
            4'h8: dec_n.alu_op = ALU_AND;
            4'h9: dec_n.alu_op = ALU_XOR;
            4'hA: dec_n.alu_op = ALU_OR;
            4'hB: begin
                dec_n.alu_op     = ALU_PASS;
                dec_n.dest_waddr = REG_LINK;
                dec_n.regf_wren  = |word[11:10];
                dec_n.pc_jmp     = word[8];
                dec_n.pc_call    = ~word[8] & ~word[9];
                dec_n.pc_ret     = ~word[8] & word[9];
            end
            4'hC: begin
                dec_n.alu_op = ALU_PASS;
                dec_n.pc_brx = |word[11:10];
            end
            4'hD: begin
                dec_n.alu_op = ALU_PASS;
                dec_n.pc_brx = 1'b1;
            end
            4'hE: begin
                dec_n.alu_op     = ALU_PASS;
                dec_n.dest_waddr = {3'b100, word[9:8]};
                dec_n.regf_wren  = 1'b1;
            end
            4'hF: begin
                dec_n.alu_op     = ALU_NONE;
                dec_n.data_ren   = (word[9:5] == REG_DATA);
                dec_n.io_ren     = (word[9:5] == REG_IO);
                dec_n.status_ren = (word[9:5] == REG_STATUS);
            end
        endcase
        if (cls <= 4'hA) begin
            dec_n.regf_wren  = 1'b1;
            dec_n.data_wren  = (word[4:0] == REG_DATA);
            dec_n.data_ren   = (word[9:5] == REG_DATA);
            dec_n.io_wren    = (word[4:0] == REG_IO);
            dec_n.io_ren     = (word[9:5] == REG_IO);
            dec_n.status_ren = (word[9:5] == REG_STATUS);
        end
    end

    // decode register: reset/flush clear it, hazard holds it (ret is a pulse, jmp/brx resettable), else load
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dec_q    <= '0;
            ifield_q <= '0;
            valid_q  <= 1'b0;
        end else if (hazard) begin
            dec_q.pc_ret <= 1'b0;
            if (jmp_rst) begin
                dec_q.pc_jmp  <= 1'b0;
                dec_q.pc_call <= 1'b0;
            end
            if (brx_rst) dec_q.pc_brx <= 1'b0;
        end else begin
            dec_q    <= dec_n;
            ifield_q <= word[IW-7:0];
            valid_q  <= word_valid;
        end
    end

    assign dec_valid  = valid_q;
    assign alu_op     = dec_q.alu_op;
    assign src_raddr  = dec_q.src_raddr;
    assign dest_waddr = dec_q.dest_waddr;
    assign I_field    = ifield_q;
    assign H_en       = dec_q.h_en;
    assign L_en       = dec_q.l_en;
    assign regf_wren  = dec_q.regf_wren;
    assign data_wren  = dec_q.data_wren;
    assign data_ren   = dec_q.data_ren;
    assign IO_wren    = dec_q.io_wren;
    assign IO_ren     = dec_q.io_ren;
    assign status_ren = dec_q.status_ren;
    assign pc_jmp     = dec_q.pc_jmp;
    assign pc_brx     = dec_q.pc_brx;
    assign pc_brxt    = dec_q.pc_brxt;
    assign pc_call    = dec_q.pc_call;
    assign pc_ret     = dec_q.pc_ret;

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized and directed bench for decode_queue; honours DECODE_QUEUE_BYPASS_EN
module tb_decode_queue;

    localparam int          IW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] NOP_W = 16'hC000;

    logic          clk = 1'b0;
    logic          rst, flush, hazard, jmp_rst, brx_rst, fetch_valid;
    logic [IW-1:0] fetch_data;
    logic          fetch_ready, dec_valid;
    logic [2:0]    q_count;
    logic [3:0]    alu_op;
    logic [4:0]    src_raddr, dest_waddr;
    logic [9:0]    I_field;
    logic          H_en, L_en, regf_wren, data_wren, data_ren, IO_wren, IO_ren, status_ren;
    logic          pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret;

    decode_queue #(.IW(IW), .DEPTH(DEPTH), .NOP_WORD(NOP_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hazard(hazard), .jmp_rst(jmp_rst), .brx_rst(brx_rst),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready), .q_count(q_count),
        .dec_valid(dec_valid), .alu_op(alu_op), .src_raddr(src_raddr), .dest_waddr(dest_waddr),
        .I_field(I_field), .H_en(H_en), .L_en(L_en), .regf_wren(regf_wren), .data_wren(data_wren),
        .data_ren(data_ren), .IO_wren(IO_wren), .IO_ren(IO_ren), .status_ren(status_ren),
        .pc_jmp(pc_jmp), .pc_brx(pc_brx), .pc_brxt(pc_brxt), .pc_call(pc_call), .pc_ret(pc_ret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic [4:0] src, dst;
        logic [9:0] ifld;
        logic h, l, rw, dw, dr, iw, ir, sr, jmp, brx, brxt, call, ret, v;
    } mexp_t;

    logic [37:0] act;
    assign act = {alu_op, src_raddr, dest_waddr, I_field, H_en, L_en, regf_wren, data_wren, data_ren,
                  IO_wren, IO_ren, status_ren, pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret, dec_valid};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mq[$];
    mexp_t       me;
    logic        obs_fr, exp_fr;

    function automatic mexp_t mdec(input logic [15:0] w, input logic v);
        mexp_t      e;
        int         c;
        logic [3:0] tab [0:10];
        tab = '{4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4, 4'h5, 4'h6};
        c = int'(w[15:12]);
        e = '0;
        e.src = w[9:5]; e.dst = w[4:0]; e.ifld = w[9:0];
        e.h = w[11]; e.l = w[10]; e.brxt = w[12]; e.v = v;
        if (c <= 10) begin
            e.alu = tab[c]; e.rw = 1'b1;
            e.dw = (e.dst == 5'd24); e.dr = (e.src == 5'd24);
            e.iw = (e.dst == 5'd25); e.ir = (e.src == 5'd25); e.sr = (e.src == 5'd30);
        end else if (c == 11) begin
            e.alu = 4'h7; e.dst = 5'd17; e.rw = w[11] | w[10];
            e.jmp = w[8]; e.call = !w[8] && !w[9]; e.ret = !w[8] && w[9];
        end else if (c == 12) begin
            e.alu = 4'h7; e.brx = w[11] | w[10];
        end else if (c == 13) begin
            e.alu = 4'h7; e.brx = 1'b1;
        end else if (c == 14) begin
            e.alu = 4'h7; e.dst = {3'b100, w[9:8]}; e.rw = 1'b1;
        end else begin
            e.alu = 4'hF;
            e.dr = (e.src == 5'd24); e.ir = (e.src == 5'd25); e.sr = (e.src == 5'd30);
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 4))
            0: w[4:0] = 5'd24;
            1: w[9:5] = 5'd24;
            2: w[4:0] = 5'd25;
            3: w[9:5] = (($urandom_range(0, 1) == 0) ? 5'd25 : 5'd30);
            default: ;
        endcase
        return w;
    endfunction

    task automatic step(input logic r, input logic f, input logic hz, input logic fv,
                        input logic [15:0] fd, input logic jr, input logic br);
        logic push, used;
        rst = r; flush = f; hazard = hz; fetch_valid = fv; fetch_data = fd; jmp_rst = jr; brx_rst = br;
        @(negedge clk);
        obs_fr = fetch_ready;
        exp_fr = !r && !f && (mq.size() != DEPTH);
        push   = fv && exp_fr;
        used   = 1'b0;
        @(posedge clk);
        if (r || f) begin
            mq.delete();
            me = '0;
        end else begin
            if (!hz) begin
                if (mq.size() > 0) me = mdec(mq.pop_front(), 1'b1);
`ifdef DECODE_QUEUE_BYPASS_EN
                else if (push) begin me = mdec(fd, 1'b1); used = 1'b1; end
`endif
                else me = mdec(NOP_W, 1'b0);
            end else begin
                me.ret = 1'b0;
                if (jr) begin me.jmp = 1'b0; me.call = 1'b0; end
                if (br) me.brx = 1'b0;
            end
            if (push && !used) mq.push_back(fd);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle();
    endtask

    task automatic load(input logic [15:0] w);
        step(1'b0, 1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0);
`ifndef DECODE_QUEUE_BYPASS_EN
        idle();
`endif
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        checks++; if (obs_fr !== 1'b0) begin errors++; $display("FAIL reset_ready act=%b exp=0", obs_fr); end
        checks++; if (act !== 38'h0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", act); end
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount act=%0d exp=0", q_count); end
        idle();
        checks++; if (obs_fr !== 1'b1) begin errors++; $display("FAIL reset_ready_after act=%b exp=1", obs_fr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_nop_valid act=%b exp=0", dec_valid); end
        checks++; if (act !== me) begin errors++; $display("FAIL reset_nop act=%h exp=%h", act, me); end
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0318, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 1'b0, 1'b0);
        checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL reset_fill act=%0d exp=2", q_count); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        idle();
        checks++; if (q_count !== 3'd0 || dec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_midop act=%0d/%b exp=0/0", q_count, dec_valid); end
    endtask

    task automatic test_add_r24();
        drain();
        load(16'h0318);
        checks++; if ({alu_op, data_wren, data_ren, regf_wren, dec_valid} !== {4'h0, 4'b1111}) begin
            errors++; $display("FAIL add_r24 act=%h/%b%b%b%b exp=0/1111", alu_op, data_wren, data_ren, regf_wren, dec_valid); end
        checks++; if (act !== me) begin errors++; $display("FAIL add_r24_model act=%h exp=%h", act, me); end
    endtask

    task automatic test_latency();
        drain();
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hE3AB, 1'b0, 1'b0);
`ifdef DECODE_QUEUE_BYPASS_EN
        checks++; if ({dest_waddr, regf_wren, dec_valid, q_count} !== {5'h13, 1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL bypass_e3ab act=%h/%b/%b/%0d exp=13/1/1/0", dest_waddr, regf_wren, dec_valid, q_count); end
`else
        checks++; if ({dec_valid, q_count} !== {1'b0, 3'd1}) begin
            errors++; $display("FAIL latency_edge_n act=%b/%0d exp=0/1", dec_valid, q_count); end
        idle();
        checks++; if ({dest_waddr, regf_wren, dec_valid, q_count} !== {5'h13, 1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL latency_e3ab act=%h/%b/%b/%0d exp=13/1/1/0", dest_waddr, regf_wren, dec_valid, q_count); end
`endif
    endtask

    task automatic test_full_hazard();
        logic [15:0] w [5];
        logic [37:0] held;
        drain();
        held = act;
        for (int k = 0; k < 5; k++) w[k] = rand_word();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, w[k], 1'b0, 1'b0);
            checks++; if (obs_fr !== (k < 4)) begin errors++; $display("FAIL full_ready k=%0d act=%b exp=%b", k, obs_fr, k < 4); end
            checks++; if (act !== held) begin errors++; $display("FAIL full_hold k=%0d act=%h exp=%h", k, act, held); end
        end
        checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_count act=%0d exp=4", q_count); end
        for (int k = 0; k < 4; k++) begin
            idle();
            checks++; if ({I_field, dec_valid} !== {w[k][9:0], 1'b1}) begin
                errors++; $display("FAIL full_order k=%0d act=%h exp=%h", k, I_field, w[k][9:0]); end
            checks++; if (act !== me) begin errors++; $display("FAIL full_decode k=%0d act=%h exp=%h", k, act, me); end
        end
        idle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL full_drained act=%b exp=0", dec_valid); end
    endtask

    task automatic test_ret_pulse();
        int cnt;
        drain();
        load(16'hB200);
        checks++; if (pc_ret !== 1'b1) begin errors++; $display("FAIL ret_first act=%b exp=1", pc_ret); end
        cnt = int'(pc_ret);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
            cnt += int'(pc_ret);
        end
        checks++; if (cnt != 1) begin errors++; $display("FAIL ret_pulse act=%0d exp=1", cnt); end
        checks++; if (act !== me) begin errors++; $display("FAIL ret_hold act=%h exp=%h", act, me); end
    endtask

    task automatic test_flush();
        drain();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, rand_word(), 1'b0, 1'b0);
        checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL flush_fill act=%0d exp=3", q_count); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0318, 1'b0, 1'b0);
        checks++; if (obs_fr !== 1'b0) begin errors++; $display("FAIL flush_ready act=%b exp=0", obs_fr); end
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", q_count); end
        checks++; if (act !== 38'h0) begin errors++; $display("FAIL flush_outputs act=%h exp=0", act); end
        idle();
        checks++; if ({q_count, dec_valid} !== 4'b0) begin errors++; $display("FAIL flush_dropped act=%0d/%b exp=0/0", q_count, dec_valid); end
    endtask

    task automatic test_jmp_brx();
        drain();
        load(16'hB100);
        checks++; if ({pc_jmp, pc_call, pc_ret} !== 3'b100) begin errors++; $display("FAIL jmp_set act=%b exp=100", {pc_jmp, pc_call, pc_ret}); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if (pc_jmp !== 1'b0) begin errors++; $display("FAIL jmp_clear act=%b exp=0", pc_jmp); end
        load(16'hB000);
        checks++; if (pc_call !== 1'b1) begin errors++; $display("FAIL call_set act=%b exp=1", pc_call); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
        checks++; if ({pc_call, alu_op} !== {1'b0, 4'h7}) begin errors++; $display("FAIL call_clear act=%b/%h exp=0/7", pc_call, alu_op); end
        idle();
        load(16'hDC00);
        checks++; if ({pc_brx, pc_brxt} !== 2'b11) begin errors++; $display("FAIL brx_set act=%b exp=11", {pc_brx, pc_brxt}); end
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        checks++; if ({pc_brx, pc_brxt} !== 2'b01) begin errors++; $display("FAIL brx_clear act=%b exp=01", {pc_brx, pc_brxt}); end
        idle();
        load(16'hC000);
        checks++; if ({pc_brx, dec_valid} !== 2'b01) begin errors++; $display("FAIL c000 act=%b exp=01", {pc_brx, dec_valid}); end
    endtask

    task automatic test_random();
        logic r, f, hz, jr, br;
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 19) == 0);
            hz = ($urandom_range(0, 2) == 0);
            jr = hz && ($urandom_range(0, 3) == 0);
            br = hz && ($urandom_range(0, 3) == 0);
            step(r, f, hz, ($urandom_range(0, 2) != 0), rand_word(), jr, br);
            checks++; if (obs_fr !== exp_fr) begin errors++; $display("FAIL rnd_ready n=%0d act=%b exp=%b", n, obs_fr, exp_fr); end
            checks++; if (q_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d act=%0d exp=%0d", n, q_count, mq.size()); end
            checks++; if (act !== me) begin errors++; $display("FAIL rnd_outputs n=%0d act=%h exp=%h", n, act, me); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hazard = 1'b0; jmp_rst = 1'b0; brx_rst = 1'b0;
        fetch_valid = 1'b0; fetch_data = '0;
        me = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_r24();
        test_latency();
        test_full_hazard();
        test_ret_pulse();
        test_flush();
        test_jmp_brx();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
